// File: rtl/aes_reduced_round_ctrl.sv
// Job sequencer around the masked reduced AES round: PRD fetch, Sp2V round handshake, NumRounds feedback.
// Optional RUN watchdog is enabled by defining AES_RRCTRL_TIMEOUT_EN.
module aes_reduced_round_ctrl #(
    parameter int unsigned NumRounds     = 2,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [1:0]   op_i,
    input  logic [127:0] data_i,
    input  logic [127:0] mask_i,
    output logic         prd_req_o,
    input  logic         prd_ack_i,
    input  logic [127:0] prd_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic [127:0] mask_o,
    output logic         alert_o,
    output logic [2:0]   rr_en_o,
    output logic         rr_prd_we_o,
    input  logic [2:0]   rr_out_req_i,
    output logic [2:0]   rr_out_ack_o,
    output logic [1:0]   rr_op_o,
    output logic [127:0] rr_data_o,
    output logic [127:0] rr_mask_o,
    output logic [127:0] rr_prd_o,
    input  logic [127:0] rr_data_i,
    input  logic [127:0] rr_mask_i,
    input  logic         rr_err_i
);

    localparam logic [2:0] SP2V_HIGH = 3'b011;
    localparam logic [2:0] SP2V_LOW  = 3'b100;
    localparam logic [3:0] LAST_ROUND = 4'(NumRounds - 1);

    if (NumRounds == 0 || NumRounds > 15 || TimeoutCycles == 0) begin : g_param_check
        $error("aes_reduced_round_ctrl: NumRounds must be 1..15 and TimeoutCycles >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRD,
        ST_LOAD,
        ST_RUN,
        ST_ACK,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   mask_q, mask_d;
    logic [127:0]   prd_q, prd_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           fault;

`ifdef AES_RRCTRL_TIMEOUT_EN
    localparam int unsigned WD_W = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TimeoutCycles - 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    // A malformed Sp2V request, a round-internal error, or a request before the round was enabled.
    always_comb begin
        fault = 1'b0;
        if (state_q != ST_IDLE) begin
            if (rr_err_i) begin
                fault = 1'b1;
            end
            if (rr_out_req_i != SP2V_HIGH && rr_out_req_i != SP2V_LOW) begin
                fault = 1'b1;
            end
            if (rr_out_req_i == SP2V_HIGH && (state_q == ST_PRD || state_q == ST_LOAD)) begin
                fault = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        mask_d  = mask_q;
        prd_d   = prd_q;
        cnt_d   = cnt_q;
`ifdef AES_RRCTRL_TIMEOUT_EN
        wdog_d  = wdog_q;
`endif
        if (fault) begin
            state_d = ST_ERROR;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        op_d    = op_i;
                        data_d  = data_i;
                        mask_d  = mask_i;
                        cnt_d   = 4'd0;
                        state_d = ST_PRD;
                    end
                end
                ST_PRD: begin
                    if (prd_ack_i) begin
                        prd_d   = prd_i;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
`ifdef AES_RRCTRL_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (rr_out_req_i == SP2V_HIGH) begin
                        state_d = ST_ACK;
                    end
`ifdef AES_RRCTRL_TIMEOUT_EN
                    else if (wdog_q == WD_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
`endif
                end
                ST_ACK: begin
                    data_d = rr_data_i;
                    mask_d = rr_mask_i;
                    if (cnt_q == LAST_ROUND) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ST_PRD;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            prd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            prd_q   <= prd_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef AES_RRCTRL_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    // Every output decodes only the state register or drives a register directly.
    assign in_ready_o   = (state_q == ST_IDLE);
    assign prd_req_o    = (state_q == ST_PRD);
    assign rr_prd_we_o  = (state_q == ST_LOAD);
    assign out_valid_o  = (state_q == ST_DONE);
    assign alert_o      = (state_q == ST_ERROR);
    assign rr_en_o      = (state_q == ST_RUN || state_q == ST_ACK) ? SP2V_HIGH : SP2V_LOW;
    assign rr_out_ack_o = (state_q == ST_ACK) ? SP2V_HIGH : SP2V_LOW;
    assign rr_op_o      = op_q;
    assign rr_data_o    = data_q;
    assign rr_mask_o    = mask_q;
    assign rr_prd_o     = (state_q == ST_ERROR) ? '0 : prd_q;
    assign data_o       = (state_q == ST_ERROR) ? '0 : data_q;
    assign mask_o       = (state_q == ST_ERROR) ? '0 : mask_q;

endmodule
